hex_display_bank: RTL and testbench
===================================

// Module: hex_display_bank
// PURPOSE
//   Parametrised bank of NUM_DISP registered seven-segment pattern registers with a write port.
//   An active-low pushbutton strobe writes one register per press.
//   The written value is either a raw segment pattern or a hex digit decoded to segments.
//   The target is the display chosen by SEL, or an internal auto-incrementing pointer.
//   Sits between board switches/keys and the HEX outputs of DE-series top levels.
// PARAMETERS
//   NUM_DISP  6           number of HEX displays, 1..8
//   SEL_W     3           width of SEL/CUR_SEL; 2**SEL_W >= NUM_DISP
//   CLK_HZ    50_000_000  CLOCK_50 frequency, used only for blink timing
//   BLINK_HZ  2           blink rate of the cursor display (HEX_BLINK_EN only)
// PORTS
//   CLOCK_50  in   1           system clock, all state on rising edge
//   RESET     in   1           asynchronous, active-high reset
//   WR_N      in   1           active-low write request, asynchronous to CLOCK_50 (pushbutton)
//   SEL       in   SEL_W       explicit target display index
//   DATA      in   7           raw segment pattern (bit i = segment i, active-low) or hex digit in DATA[3:0]
//   MODE      in   1           0 = store DATA raw; 1 = store decode(DATA[3:0])
//   AUTO_INC  in   1           0 = target is SEL; 1 = target is internal pointer
//   HEX       out  NUM_DISP*7  display d on HEX[7*d+6:7*d], active-low segments
//   CUR_SEL   out  SEL_W       internal pointer = next auto-increment target
//   WR_DONE   out  1           one-cycle pulse after each accepted write
// BEHAVIOUR
//   Reset (async assert, sync to clock edge irrelevant): every HEX digit = 7'h7F (blank);
//     ptr = 0; WR_DONE = 0; WR_N synchroniser flops = 1.
//   WR_N passes through a 2-flop synchroniser (s1, s2) and a history flop s3.
//   Write event = s2==0 && s3==1: one event per falling edge.
//     Holding WR_N low gives exactly one write. There is no debounce; benches drive clean edges.
//   Latency: edge k is the first edge at which s1 samples 0.
//     The event is seen after edge k+1; the register updates at edge k+2.
//     WR_DONE is high for the cycle after edge k+2.
//   Target t = AUTO_INC ? ptr : SEL.
//     SEL and MODE are sampled at the write edge, not when the button was pressed.
//   Accepted write when t < NUM_DISP:
//     digit[t] <= MODE ? decode(DATA[3:0]) : DATA;
//     ptr <= (t == NUM_DISP-1) ? 0 : t+1;
//     WR_DONE <= 1.
//   Rejected write when t >= NUM_DISP (only possible via SEL):
//     no digit change, ptr unchanged, WR_DONE stays 0.
//   decode (active-low): 0->40 1->79 2->24 3->30 4->19 5->12 6->02 7->78
//     8->00 9->10 A->08 b->03 C->46 d->21 E->06 F->0E.
//   Unwritten digits hold their value indefinitely; DATA/SEL changes without a write have no effect.
//   RESET asserted mid-synchronisation discards any pending write.
//   CUR_SEL = ptr at all times.
// CONFIGURATION
//   HEX_BLINK_EN defined:
//     Prescaler counts 0..CLK_HZ/(2*BLINK_HZ)-1; on wrap, phase toggles.
//     While phase==1, digit[ptr] is shown as 7'h7F; stored values are unaffected.
//     An accepted write clears prescaler and phase in the same edge, so the cursor is shown immediately.
//     Reset clears prescaler and phase to 0.
//     If ptr >= NUM_DISP is impossible, no out-of-range blanking logic is needed.
//   HEX_BLINK_EN undefined:
//     No prescaler or phase logic; HEX = stored digits, purely registered.
// TESTING
//   1 Reset: RESET=1 for 3 cycles -> HEX all 7'h7F, CUR_SEL=0, WR_DONE=0.
//   2 Raw write: AUTO_INC=0, SEL=2, MODE=0, DATA=7'h12, WR_N low at edge k ->
//     HEX[20:14]=7'h12 after edge k+2, WR_DONE=1 for exactly 1 cycle, CUR_SEL=3, other digits 7'h7F.
//   3 Decode + wrap: AUTO_INC=1, MODE=1, DATA=4'hA, 7 presses ->
//     digits 0..5 = 7'h08 after press 6, CUR_SEL=0; press 7 rewrites digit 0; CUR_SEL=1.
//   4 Invalid and held: SEL=6, AUTO_INC=0, one press -> no change, no WR_DONE;
//     then SEL=1, WR_N held low 100 cycles -> exactly one WR_DONE.
//   5 Reset mid-op: WR_N falls, RESET pulses at edge k+1 ->
//     no write, all 7'h7F; WR_N still low after reset -> no write until released and pressed again.
//   6 HEX_BLINK_EN, CLK_HZ=8, BLINK_HZ=1: after a write to 0 (ptr=1) ->
//     digit 1 alternates stored/7'h7F every 4 cycles; a write mid-blank restores visibility next cycle.

Source files
------------

// File: rtl/hex_display_bank_if.sv
// Switch/key side bundle for hex_display_bank: write request, target, data and
// the segment/pointer/status outputs. Master = board glue, slave = the bank.
interface hex_display_bank_if #(
   parameter int NUM_DISP = 6,
   parameter int SEL_W    = 3
);
   logic                  WR_N;
   logic [SEL_W-1:0]      SEL;
   logic [6:0]            DATA;
   logic                  MODE;
   logic                  AUTO_INC;
   logic [NUM_DISP*7-1:0] HEX;
   logic [SEL_W-1:0]      CUR_SEL;
   logic                  WR_DONE;

   modport master (
      output WR_N, SEL, DATA, MODE, AUTO_INC,
      input  HEX, CUR_SEL, WR_DONE
   );

   modport slave (
      input  WR_N, SEL, DATA, MODE, AUTO_INC,
      output HEX, CUR_SEL, WR_DONE
   );
endinterface

// File: rtl/hex_display_bank.sv
// Bank of NUM_DISP seven-segment registers written one per WR_N press, raw or hex-decoded.
// Define HEX_BLINK_EN to blink the display at the auto-increment pointer at BLINK_HZ.
module hex_display_bank #(
   parameter int NUM_DISP = 6,
   parameter int SEL_W    = 3,
   parameter int CLK_HZ   = 50_000_000,
   parameter int BLINK_HZ = 2
) (
   input logic               CLOCK_50,
   input logic               RESET,
   hex_display_bank_if.slave bus
);

   localparam logic [SEL_W:0]   NUM_DISP_W = (SEL_W+1)'(NUM_DISP);
   localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_DISP - 1);

   if (NUM_DISP < 1 || NUM_DISP > 8 || (1 << SEL_W) < NUM_DISP ||
       BLINK_HZ < 1 || CLK_HZ < 2*BLINK_HZ) begin : g_bad_param
      $error("hex_display_bank: illegal parameter combination");
   end

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic             s1_q, s2_q, s3_q;
   logic             r1_q, r2_q;
   logic [6:0]       digit_q [NUM_DISP];
   logic [6:0]       digit_d [NUM_DISP];
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             wr_done_q, wr_done_d;
   logic             wr_event;
   logic             accept;
   logic [SEL_W-1:0] target;
   logic [6:0]       wr_val;

   // r1/r2 mark when s2 holds a genuine WR_N sample; until then the history flop
   // stays 0, so a button still held low across reset cannot produce a write.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b0;
         r1_q <= 1'b0;
         r2_q <= 1'b0;
      end else begin
         s1_q <= bus.WR_N;
         s2_q <= s1_q;
         s3_q <= s2_q & r2_q;
         r1_q <= 1'b1;
         r2_q <= r1_q;
      end
   end

   assign wr_event = ~s2_q & s3_q;
   assign target   = bus.AUTO_INC ? ptr_q : bus.SEL;
   assign accept   = wr_event && ({1'b0, target} < NUM_DISP_W);
   assign wr_val   = bus.MODE ? seg_decode(bus.DATA[3:0]) : bus.DATA;

   always_comb begin
      digit_d   = digit_q;
      ptr_d     = ptr_q;
      wr_done_d = 1'b0;
      if (accept) begin
         for (int d = 0; d < NUM_DISP; d++) begin
            if (target == SEL_W'(d)) digit_d[d] = wr_val;
         end
         ptr_d     = (target == LAST_IDX) ? '0 : target + 1'b1;
         wr_done_d = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         for (int d = 0; d < NUM_DISP; d++) digit_q[d] <= 7'h7F;
         ptr_q     <= '0;
         wr_done_q <= 1'b0;
      end else begin
         digit_q   <= digit_d;
         ptr_q     <= ptr_d;
         wr_done_q <= wr_done_d;
      end
   end

`ifdef HEX_BLINK_EN
   localparam int               PRESC_N    = CLK_HZ / (2*BLINK_HZ);
   localparam int               PRESC_W    = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_N - 1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               phase_q, phase_d;

   // A write restarts the half-period so the new cursor is visible at once.
   always_comb begin
      presc_d = presc_q + 1'b1;
      phase_d = phase_q;
      if (accept) begin
         presc_d = '0;
         phase_d = 1'b0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         presc_q <= '0;
         phase_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         phase_q <= phase_d;
      end
   end
`endif

   logic [NUM_DISP*7-1:0] hex_w;

   always_comb begin
      hex_w = '0;
      for (int d = 0; d < NUM_DISP; d++) begin
`ifdef HEX_BLINK_EN
         hex_w[7*d +: 7] = (phase_q && ptr_q == SEL_W'(d)) ? 7'h7F : digit_q[d];
`else
         hex_w[7*d +: 7] = digit_q[d];
`endif
      end
   end

   assign bus.HEX     = hex_w;
   assign bus.CUR_SEL = ptr_q;
   assign bus.WR_DONE = wr_done_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank: reset, raw/decoded writes, wrap, rejects,
// held button, reset during synchronisation, and cursor blink when HEX_BLINK_EN is set.
module tb_hex_display_bank;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hex_display_bank_if #(.NUM_DISP(6), .SEL_W(3)) bus ();
   hex_display_bank #(.NUM_DISP(6), .SEL_W(3)) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .bus      (bus)
   );

`ifdef HEX_BLINK_EN
   hex_display_bank_if #(.NUM_DISP(6), .SEL_W(3)) bus_b ();
   hex_display_bank #(.NUM_DISP(6), .SEL_W(3), .CLK_HZ(8), .BLINK_HZ(1)) dut_b (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .bus      (bus_b)
   );
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int d0;

   logic [6:0]  dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [41:0] all_blank = {6{7'h7F}};
   logic [41:0] hex_snap;
   logic [2:0]  ptr_snap;
   logic [3:0]  nib;

   always @(negedge clk) if (bus.WR_DONE === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] dig(input int d);
      return bus.HEX[7*d +: 7];
   endfunction

   task automatic press(input logic [2:0] sel, input logic [6:0] data,
                        input logic mode, input logic ai);
      @(negedge clk);
      bus.SEL = sel; bus.DATA = data; bus.MODE = mode; bus.AUTO_INC = ai; bus.WR_N = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.WR_N = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

`ifdef HEX_BLINK_EN
   function automatic logic [6:0] dig_b(input int d);
      return bus_b.HEX[7*d +: 7];
   endfunction

   task automatic press_b(input logic [2:0] sel, input logic [6:0] data);
      @(negedge clk);
      bus_b.SEL = sel; bus_b.DATA = data; bus_b.MODE = 1'b0; bus_b.AUTO_INC = 1'b0;
      bus_b.WR_N = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus_b.WR_N = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask
`endif

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.WR_N = 1'b1; bus.SEL = '0; bus.DATA = '0; bus.MODE = 1'b0; bus.AUTO_INC = 1'b0;
`ifdef HEX_BLINK_EN
      bus_b.WR_N = 1'b1; bus_b.SEL = '0; bus_b.DATA = '0; bus_b.MODE = 1'b0; bus_b.AUTO_INC = 1'b0;
`endif
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hex", bus.HEX, all_blank);
      chk("rst_cur_sel", bus.CUR_SEL, 3'd0);
      chk("rst_wr_done", bus.WR_DONE, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // Raw write with exact latency
      @(negedge clk);
      bus.SEL = 3'd2; bus.DATA = 7'h12; bus.MODE = 1'b0; bus.AUTO_INC = 1'b0; bus.WR_N = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("raw_k1_digit", dig(2), 7'h7F);
      chk("raw_k1_done", bus.WR_DONE, 1'b0);
      @(posedge clk); #1;
      chk("raw_k2_hex", bus.HEX, {7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h7F, 7'h7F});
      chk("raw_k2_done", bus.WR_DONE, 1'b1);
      chk("raw_cur_sel", bus.CUR_SEL, 3'd3);
      @(posedge clk); #1;
      chk("raw_done_pulse", bus.WR_DONE, 1'b0);
      @(negedge clk);
      bus.WR_N = 1'b1;
      repeat (3) @(posedge clk);

      // Auto-increment decode and wrap
      do_reset();
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) press(3'd7, 7'h0A, 1'b1, 1'b1);
      chk("wrap_hex", bus.HEX, {6{7'h08}});
      chk("wrap_cur_sel", bus.CUR_SEL, 3'd0);
      press(3'd7, 7'h05, 1'b1, 1'b1);
      chk("wrap_rewrite_d0", dig(0), 7'h12);
      chk("wrap_d1_kept", dig(1), 7'h08);
      chk("wrap_cur_sel2", bus.CUR_SEL, 3'd1);
      chk("wrap_done_cnt", done_cnt - d0, 7);

      // Full decode table, upper DATA bits must be ignored in decode mode
      for (int v = 0; v < 16; v++) begin
         nib = v[3:0];
         press(3'(v % 6), {3'b101, nib}, 1'b1, 1'b0);
         chk($sformatf("dec_%0h", v), dig(v % 6), dec_tab[v]);
      end
      press(3'd5, 7'h55, 1'b0, 1'b0);
      chk("raw_55", dig(5), 7'h55);
      chk("raw_55_cur_sel", bus.CUR_SEL, 3'd0);

      // Rejected targets, then a long hold gives one write
      hex_snap = bus.HEX;
      ptr_snap = bus.CUR_SEL;
      d0 = done_cnt;
      press(3'd6, 7'h01, 1'b0, 1'b0);
      press(3'd7, 7'h02, 1'b0, 1'b0);
      chk("rej_hex", bus.HEX, hex_snap);
      chk("rej_cur_sel", bus.CUR_SEL, ptr_snap);
      chk("rej_done", done_cnt - d0, 0);
      @(negedge clk);
      bus.SEL = 3'd1; bus.DATA = 7'h33; bus.MODE = 1'b0; bus.AUTO_INC = 1'b0; bus.WR_N = 1'b0;
      d0 = done_cnt;
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("hold_done", done_cnt - d0, 1);
      chk("hold_digit", dig(1), 7'h33);
      chk("hold_cur_sel", bus.CUR_SEL, 3'd2);
      bus.WR_N = 1'b1;
      repeat (3) @(posedge clk);

      // Reset during synchronisation discards the write; held button stays ignored
      @(negedge clk);
      bus.SEL = 3'd3; bus.DATA = 7'h11; bus.WR_N = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rmid_hex", bus.HEX, all_blank);
      chk("rmid_cur_sel", bus.CUR_SEL, 3'd0);
      chk("rmid_done", bus.WR_DONE, 1'b0);
      d0 = done_cnt;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("rmid_held_done", done_cnt - d0, 0);
      chk("rmid_held_hex", bus.HEX, all_blank);
      bus.WR_N = 1'b1;
      repeat (3) @(posedge clk);
      press(3'd4, 7'h2A, 1'b0, 1'b0);
      chk("rmid_repress_digit", dig(4), 7'h2A);
      chk("rmid_repress_done", done_cnt - d0, 1);
      chk("rmid_repress_cur", bus.CUR_SEL, 3'd5);

`ifdef HEX_BLINK_EN
      // Cursor blink: 4-cycle half period
      press_b(3'd1, 7'h01);
      @(negedge clk);
      bus_b.SEL = 3'd0; bus_b.DATA = 7'h02; bus_b.WR_N = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      chk("blink_w_d1", dig_b(1), 7'h01);
      chk("blink_w_d0", dig_b(0), 7'h02);
      chk("blink_w_cur", bus_b.CUR_SEL, 3'd1);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         chk($sformatf("blink_c%0d", i), dig_b(1), (i >= 4 && i <= 7) ? 7'h7F : 7'h01);
         chk($sformatf("blink_d0_c%0d", i), dig_b(0), 7'h02);
      end
      @(negedge clk);
      bus_b.WR_N = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus_b.SEL = 3'd0; bus_b.DATA = 7'h04; bus_b.WR_N = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("blink_mid_blank", dig_b(1), 7'h7F);
      @(posedge clk); #1;
      chk("blink_mid_restore", dig_b(1), 7'h01);
      chk("blink_mid_d0", dig_b(0), 7'h04);
      chk("blink_mid_done", bus_b.WR_DONE, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("blink_mid_vis3", dig_b(1), 7'h01);
      @(posedge clk); #1;
      chk("blink_mid_blank2", dig_b(1), 7'h7F);
      @(negedge clk);
      bus_b.WR_N = 1'b1;
      repeat (3) @(posedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
